// File: rtl/irrigation_demand_ctrl_if.sv
// Signal bundle between the moisture sensor front end, the demand controller and
// the level controller.
interface irrigation_demand_ctrl_if;
    logic [7:0] umidade;
    logic       sample_valid;
    logic       clr_fault;
    logic       start_fill;
    logic       fault;
    logic [1:0] estado;
    logic [7:0] n_regas;

    modport master (
        output umidade, sample_valid, clr_fault,
        input  start_fill, fault, estado, n_regas
    );

    modport slave (
        input  umidade, sample_valid, clr_fault,
        output start_fill, fault, estado, n_regas
    );
endinterface

// File: rtl/irrigation_demand_ctrl.sv
// Soil-moisture demand controller: turns sensor samples into the start_fill request,
// with hysteresis, dry confirmation, hold-off, request timeout and sensor watchdog.
module irrigation_demand_ctrl #(
    parameter logic [7:0] LOW_TH         = 8'd60,
    parameter logic [7:0] HIGH_TH        = 8'd120,
    parameter int         DRY_COUNT      = 4,
    parameter int         HOLDOFF_CYCLES = 16,
    parameter int         MAX_REQ_CYCLES = 1024,
    parameter int         WDOG_CYCLES    = 256
) (
    input  logic                     Ctrl_clk,
    input  logic                     reset,
    irrigation_demand_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [8:0]  DRY_TGT   = 9'(DRY_COUNT);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);
    localparam logic [15:0] REQ_LAST  = 16'(MAX_REQ_CYCLES - 1);
    localparam logic [15:0] WD_LAST   = 16'(WDOG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  dry_cnt_q, dry_cnt_d;
    logic [15:0] req_cnt_q, req_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic [7:0]  n_regas_q, n_regas_d;
    logic        start_fill_q, start_fill_d;
    logic        fault_q, fault_d;

    logic        dry_sample_s;
    logic        wet_sample_s;
    logic        wd_trip_s;
    logic [8:0]  dry_inc_s;

    assign dry_sample_s = bus.sample_valid && (bus.umidade < LOW_TH);
    assign wet_sample_s = bus.sample_valid && (bus.umidade >= HIGH_TH);
    assign wd_trip_s    = (state_q != ST_FAULT) && !bus.sample_valid && (wd_cnt_q == WD_LAST);
    assign dry_inc_s    = {1'b0, dry_cnt_q} + 9'd1;

    // State and counter registers, synchronous reset
    always_ff @(posedge Ctrl_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dry_cnt_q    <= 8'd0;
            req_cnt_q    <= 16'd0;
            hold_cnt_q   <= 16'd0;
            wd_cnt_q     <= 16'd0;
            n_regas_q    <= 8'd0;
            start_fill_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dry_cnt_q    <= dry_cnt_d;
            req_cnt_q    <= req_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            n_regas_q    <= n_regas_d;
            start_fill_q <= start_fill_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state logic; the sensor watchdog overrides every other transition
    always_comb begin
        state_d = state_q;
        if (wd_trip_s) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dry_sample_s && (dry_inc_s == DRY_TGT)) begin
                        state_d = ST_REQUEST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQUEST: begin
                    // A satisfied sample beats a simultaneous timeout
                    if (wet_sample_s) begin
                        state_d = ST_HOLDOFF;
                    end else if (req_cnt_q == REQ_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_REQUEST;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end
                ST_FAULT: begin
                    if (bus.clr_fault) begin
                        state_d = ST_HOLDOFF;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counters restart on every state entry, so none of them can wrap
    always_comb begin
        dry_cnt_d = 8'd0;
        if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
            if (bus.sample_valid) begin
                dry_cnt_d = dry_sample_s ? dry_inc_s[7:0] : 8'd0;
            end else begin
                dry_cnt_d = dry_cnt_q;
            end
        end else begin
            dry_cnt_d = 8'd0;
        end

        req_cnt_d  = ((state_q == ST_REQUEST) && (state_d == ST_REQUEST)) ? req_cnt_q + 16'd1 : 16'd0;
        hold_cnt_d = ((state_q == ST_HOLDOFF) && (state_d == ST_HOLDOFF)) ? hold_cnt_q + 16'd1 : 16'd0;

        if ((state_q == ST_FAULT) || (state_d == ST_FAULT) || bus.sample_valid) begin
            wd_cnt_d = 16'd0;
        end else begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end

        if ((state_q == ST_REQUEST) && (state_d == ST_HOLDOFF) && (n_regas_q != 8'd255)) begin
            n_regas_d = n_regas_q + 8'd1;
        end else begin
            n_regas_d = n_regas_q;
        end
    end

    // Output decode from the next state so outputs move with the transition edge
    always_comb begin
        start_fill_d = (state_d == ST_REQUEST);
        fault_d      = (state_d == ST_FAULT);
    end

    assign bus.start_fill = start_fill_q;
    assign bus.fault      = fault_q;
    assign bus.estado     = state_q;
    assign bus.n_regas    = n_regas_q;

endmodule

// File: tb/tb_irrigation_demand_ctrl.sv
// Directed bench for irrigation_demand_ctrl: a vector table for the single-step
// behaviour plus hand-written sequences for timeouts, watchdog and reset.
module tb_irrigation_demand_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    irrigation_demand_ctrl_if bus();

    irrigation_demand_ctrl dut (
        .Ctrl_clk (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] um;
        logic       clr;
        int         ncyc;
        logic [1:0] exp_estado;
        logic       exp_sf;
        logic       exp_fault;
        logic [7:0] exp_nregas;
    } vec_t;

    vec_t vecs[18];

    task automatic step(input logic sv, input logic [7:0] um, input logic clr);
        bus.sample_valid = sv;
        bus.umidade      = um;
        bus.clr_fault    = clr;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.clr_fault    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] est, input logic sf,
                           input logic flt, input logic [7:0] nr);
        chk({name, ".estado"},     int'(bus.estado),     int'(est));
        chk({name, ".start_fill"}, int'(bus.start_fill), int'(sf));
        chk({name, ".fault"},      int'(bus.fault),      int'(flt));
        chk({name, ".n_regas"},    int'(bus.n_regas),    int'(nr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.umidade      = 8'd0;
        bus.clr_fault    = 1'b0;

        // T1: four dry samples request; T2: 119 holds, 120 ends; then hysteresis clears dry_cnt
        vecs[0]  = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'd50,  1'b0, 1,  2'd1, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 8'd119, 1'b0, 1,  2'd1, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 8'd0,   1'b0, 3,  2'd1, 1'b1, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 8'd120, 1'b0, 1,  2'd2, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 8'd0,   1'b0, 15, 2'd2, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 8'd0,   1'b0, 1,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 8'd70,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{1'b1, 8'd50,  1'b0, 4,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 8'd50,  1'b0, 1,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[16] = '{1'b0, 8'd0,   1'b0, 3,  2'd0, 1'b0, 1'b0, 8'd1};
        vecs[17] = '{1'b1, 8'd50,  1'b0, 1,  2'd1, 1'b1, 1'b0, 8'd1};

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].sv, vecs[i].um, vecs[i].clr);
            if (vecs[i].ncyc > 1) idle(vecs[i].ncyc - 1);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_estado, vecs[i].exp_sf,
                    vecs[i].exp_fault, vecs[i].exp_nregas);
        end

        // T3: request timeout after 1024 clocks, sticky fault, clear through hold-off
        for (int i = 0; i < 1023; i++) step(i % 4 == 0, 8'd50, 1'b0);
        chk_all("t3_pre_timeout", 2'd1, 1'b1, 1'b0, 8'd1);
        step(1'b0, 8'd50, 1'b0);
        chk_all("t3_timeout", 2'd3, 1'b0, 1'b1, 8'd1);
        idle(5);
        chk_all("t3_sticky", 2'd3, 1'b0, 1'b1, 8'd1);
        step(1'b0, 8'd0, 1'b1);
        chk_all("t3_clear", 2'd2, 1'b0, 1'b0, 8'd1);
        idle(15);
        chk_all("t3_hold15", 2'd2, 1'b0, 1'b0, 8'd1);
        idle(1);
        chk_all("t3_idle", 2'd0, 1'b0, 1'b0, 8'd1);

        // T4: watchdog trips on the 256th silent edge
        step(1'b1, 8'd100, 1'b0);
        idle(255);
        chk_all("t4_wd255", 2'd0, 1'b0, 1'b0, 8'd1);
        idle(1);
        chk_all("t4_wd_trip", 2'd3, 1'b0, 1'b1, 8'd1);
        step(1'b0, 8'd0, 1'b1);
        idle(16);
        chk_all("t4_recover", 2'd0, 1'b0, 1'b0, 8'd1);

        // T4b: a strobe on clock 255 keeps the watchdog quiet
        step(1'b1, 8'd100, 1'b0);
        idle(254);
        step(1'b1, 8'd100, 1'b0);
        idle(1);
        chk_all("t4_strobe_saves", 2'd0, 1'b0, 1'b0, 8'd1);
        idle(100);
        chk_all("t4_still_idle", 2'd0, 1'b0, 1'b0, 8'd1);

        // T5: reset mid-REQUEST, then a full four dry samples are needed again
        for (int i = 0; i < 4; i++) step(1'b1, 8'd50, 1'b0);
        chk_all("t5_request", 2'd1, 1'b1, 1'b0, 8'd1);
        reset = 1'b1;
        step(1'b1, 8'd50, 1'b0);
        reset = 1'b0;
        chk_all("t5_reset", 2'd0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd50, 1'b0);
        chk_all("t5_three_dry", 2'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 8'd50, 1'b0);
        chk_all("t5_four_dry", 2'd1, 1'b1, 1'b0, 8'd0);

        // T6: satisfied sample coinciding with the last request clock wins
        for (int i = 0; i < 1023; i++) step(i % 4 == 1, 8'd100, 1'b0);
        chk_all("t6_pre", 2'd1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 8'd130, 1'b0);
        chk_all("t6_wet_wins", 2'd2, 1'b0, 1'b0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
